// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types: stage destination tag, Tnew/Tuse encodings, mult/div latencies.
package hazard_scoreboard_pkg;

  typedef struct packed {
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_tag_t;

  localparam logic [1:0] TNEW_NOW  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  localparam int MD_CNT_W         = 4;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  // The younger E stage shadows M; a W producer is always reachable through write-through.
  function automatic logic operand_stall(input logic       rd_en,
                                         input logic [4:0] rd_reg,
                                         input logic [1:0] tuse,
                                         input stage_tag_t e_tag,
                                         input stage_tag_t m_tag);
    logic hit;
    hit = 1'b0;
    if (rd_en && (rd_reg != 5'd0)) begin
      if (e_tag.we && (e_tag.a3 == rd_reg))
        hit = (e_tag.tnew > tuse);
      else if (m_tag.we && (m_tag.a3 == rd_reg))
        hit = (m_tag.tnew > tuse);
    end
    return hit;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Mult/div busy countdown: start loads the latency, then counts down to zero.
// busy is asserted combinationally in the start cycle and while the count is nonzero.
module md_busy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = is_div_i ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = start_i | (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: per-stage GPR write tags for bypass muxes,
// same-cycle stall decision against D's Tuse, and mult/div busy tracking.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_rs_use,
  input  logic       D_rt_use,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_we,
  input  logic [4:0] D_a3,
  input  logic [1:0] D_tnew,
  input  logic       D_md_use,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  output logic       GRFWE_E,
  output logic       GRFWE_M,
  output logic       GRFWE_W,
  output logic [4:0] E_A3,
  output logic [4:0] M_A3,
  output logic [4:0] W_A3,
  output logic [1:0] E_tnew,
  output logic [1:0] M_tnew,
  output logic       md_busy,
  output logic       stall
);

  stage_tag_t e_tag_q, e_tag_d;
  stage_tag_t m_tag_q, m_tag_d;
  stage_tag_t w_tag_q, w_tag_d;
  logic       stall_rs, stall_rt, stall_md;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (E_md_start),
    .is_div_i (E_md_is_div),
    .busy_o   (md_busy)
  );

  assign stall_rs = operand_stall(D_rs_use, D_rs, D_tuse_rs, e_tag_q, m_tag_q);
  assign stall_rt = operand_stall(D_rt_use, D_rt, D_tuse_rt, e_tag_q, m_tag_q);
  assign stall_md = D_md_use & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  always_comb begin
    e_tag_d = '0;
    if (!stall) begin
      e_tag_d.we   = D_we & (D_a3 != 5'd0);
      e_tag_d.a3   = D_a3;
      e_tag_d.tnew = D_tnew;
    end

    m_tag_d = e_tag_q;
    if (e_tag_q.tnew != 2'd0)
      m_tag_d.tnew = e_tag_q.tnew - 2'd1;

    // Every result is ready by W, so its Tnew is pinned to zero.
    w_tag_d      = m_tag_q;
    w_tag_d.tnew = TNEW_NOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_tag_q <= '0;
      m_tag_q <= '0;
      w_tag_q <= '0;
    end else begin
      e_tag_q <= e_tag_d;
      m_tag_q <= m_tag_d;
      w_tag_q <= w_tag_d;
    end
  end

  assign GRFWE_E = e_tag_q.we;
  assign GRFWE_M = m_tag_q.we;
  assign GRFWE_W = w_tag_q.we;
  assign E_A3    = e_tag_q.a3;
  assign M_A3    = m_tag_q.a3;
  assign W_A3    = w_tag_q.a3;
  assign E_tnew  = e_tag_q.tnew;
  assign M_tnew  = m_tag_q.tnew;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with a scoreboard queue of expected outputs.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_use;
    logic       rt_use;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       we;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md_use;
    logic       md_start;
    logic       md_div;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       we_e;
    logic [4:0] a3_e;
    logic [1:0] tnew_e;
    logic       we_m;
    logic [4:0] a3_m;
    logic [1:0] tnew_m;
    logic       we_w;
    logic [4:0] a3_w;
    logic       busy;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_a3;
  logic       D_rs_use, D_rt_use, D_we, D_md_use, E_md_start, E_md_is_div;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       GRFWE_E, GRFWE_M, GRFWE_W, md_busy, stall;
  logic [4:0] E_A3, M_A3, W_A3;
  logic [1:0] E_tnew, M_tnew;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_rs_use    (D_rs_use),
    .D_rt_use    (D_rt_use),
    .D_tuse_rs   (D_tuse_rs),
    .D_tuse_rt   (D_tuse_rt),
    .D_we        (D_we),
    .D_a3        (D_a3),
    .D_tnew      (D_tnew),
    .D_md_use    (D_md_use),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .GRFWE_E     (GRFWE_E),
    .GRFWE_M     (GRFWE_M),
    .GRFWE_W     (GRFWE_W),
    .E_A3        (E_A3),
    .M_A3        (M_A3),
    .W_A3        (W_A3),
    .E_tnew      (E_tnew),
    .M_tnew      (M_tnew),
    .md_busy     (md_busy),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vt[16];
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic in_t I(input int rs, input int rt, input int rsu, input int rtu,
                            input int trs, input int trt, input int we, input int a3,
                            input int tnew, input int mdu, input int mds, input int mdd);
    in_t v;
    v.rs = 5'(rs);        v.rt = 5'(rt);
    v.rs_use = 1'(rsu);   v.rt_use = 1'(rtu);
    v.tuse_rs = 2'(trs);  v.tuse_rt = 2'(trt);
    v.we = 1'(we);        v.a3 = 5'(a3);       v.tnew = 2'(tnew);
    v.md_use = 1'(mdu);   v.md_start = 1'(mds); v.md_div = 1'(mdd);
    return v;
  endfunction

  function automatic exp_t X(input int st, input int we_e, input int a3_e, input int tn_e,
                             input int we_m, input int a3_m, input int tn_m,
                             input int we_w, input int a3_w, input int busy);
    exp_t e;
    e.stall = 1'(st);
    e.we_e = 1'(we_e); e.a3_e = 5'(a3_e); e.tnew_e = 2'(tn_e);
    e.we_m = 1'(we_m); e.a3_m = 5'(a3_m); e.tnew_m = 2'(tn_m);
    e.we_w = 1'(we_w); e.a3_w = 5'(a3_w);
    e.busy = 1'(busy);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.stall = stall;
    o.we_e = GRFWE_E; o.a3_e = E_A3; o.tnew_e = E_tnew;
    o.we_m = GRFWE_M; o.a3_m = M_A3; o.tnew_m = M_tnew;
    o.we_w = GRFWE_W; o.a3_w = W_A3;
    o.busy = md_busy;
    return o;
  endfunction

  task automatic apply(input in_t v);
    D_rs = v.rs;           D_rt = v.rt;
    D_rs_use = v.rs_use;   D_rt_use = v.rt_use;
    D_tuse_rs = v.tuse_rs; D_tuse_rt = v.tuse_rt;
    D_we = v.we;           D_a3 = v.a3;           D_tnew = v.tnew;
    D_md_use = v.md_use;   E_md_start = v.md_start; E_md_is_div = v.md_div;
  endtask

  task automatic check(input string name);
    exp_t a, e;
    a = observe();
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got %h (stall=%b E=%b/%0d/%0d M=%b/%0d/%0d W=%b/%0d busy=%b) expected %h (stall=%b E=%b/%0d/%0d M=%b/%0d/%0d W=%b/%0d busy=%b)",
                 name, a, a.stall, a.we_e, a.a3_e, a.tnew_e, a.we_m, a.a3_m, a.tnew_m, a.we_w, a.a3_w, a.busy,
                 e, e.stall, e.we_e, e.a3_e, e.tnew_e, e.we_m, e.a3_m, e.tnew_m, e.we_w, e.a3_w, e.busy);
      end
    end
  endtask

  task automatic step(input in_t v, input exp_t e, input string name);
    @(negedge clk);
    apply(v);
    sb_q.push_back(e);
    #1;
    check(name);
  endtask

  initial begin
    // lw/addu dependency, bubble, ALU back-to-back, shadowing, $0, W never stalls.
    vt[0]  = '{I(0,0,0,0,0,0, 1,1,2, 0,0,0), X(0, 0,0,0, 0,0,0, 0,0, 0)};
    vt[1]  = '{I(1,0,1,0,1,0, 1,5,1, 0,0,0), X(1, 1,1,2, 0,0,0, 0,0, 0)};
    vt[2]  = '{I(1,0,1,0,1,0, 1,5,1, 0,0,0), X(0, 0,0,0, 1,1,1, 0,0, 0)};
    vt[3]  = '{I(0,0,0,0,0,0, 1,2,1, 0,0,0), X(0, 1,5,1, 0,0,0, 1,1, 0)};
    vt[4]  = '{I(2,2,1,1,1,1, 1,3,1, 0,0,0), X(0, 1,2,1, 1,5,0, 0,0, 0)};
    vt[5]  = '{I(3,0,1,1,0,0, 0,0,0, 0,0,0), X(1, 1,3,1, 1,2,0, 1,5, 0)};
    vt[6]  = '{I(3,0,1,1,0,0, 0,0,0, 0,0,0), X(0, 0,0,0, 1,3,0, 1,2, 0)};
    vt[7]  = '{I(0,0,0,0,0,0, 1,3,2, 0,0,0), X(0, 0,0,0, 0,0,0, 1,3, 0)};
    vt[8]  = '{I(0,0,0,0,0,0, 1,3,0, 0,0,0), X(0, 1,3,2, 0,0,0, 0,0, 0)};
    vt[9]  = '{I(3,0,1,0,0,0, 0,0,0, 0,0,0), X(0, 1,3,0, 1,3,1, 0,0, 0)};
    vt[10] = '{I(0,0,0,0,0,0, 1,0,1, 0,0,0), X(0, 0,0,0, 1,3,0, 1,3, 0)};
    vt[11] = '{I(0,0,1,0,0,0, 0,0,0, 0,0,0), X(0, 0,0,1, 0,0,0, 1,3, 0)};
    vt[12] = '{I(0,0,0,0,0,0, 1,4,2, 0,0,0), X(0, 0,0,0, 0,0,0, 0,0, 0)};
    vt[13] = '{I(0,0,0,0,0,0, 0,0,0, 0,0,0), X(0, 1,4,2, 0,0,0, 0,0, 0)};
    vt[14] = '{I(0,4,0,1,0,0, 0,0,0, 0,0,0), X(1, 0,0,0, 1,4,1, 0,0, 0)};
    vt[15] = '{I(0,4,0,1,0,0, 0,0,0, 0,0,0), X(0, 0,0,0, 0,0,0, 1,4, 0)};

    apply(I(0,0,0,0,0,0, 0,0,0, 0,0,0));
    reset = 1'b1;
    sb_q.push_back(X(0, 0,0,0, 0,0,0, 0,0, 0));
    #1;
    check("reset");
    #2 reset = 1'b0;

    for (int i = 0; i < 16; i++)
      step(vt[i].in, vt[i].ex, $sformatf("vec%0d", i));

    // Div with mflo held in D: start cycle plus 10 countdown cycles.
    for (int k = 0; k < 12; k++)
      step(I(0,0,0,0,0,0, 0,0,0, 1, (k == 0), 1),
           X((k <= 10), 0,0,0, 0,0,0, 0,0, (k <= 10)), $sformatf("div%0d", k));

    for (int k = 0; k < 8; k++)
      step(I(0,0,0,0,0,0, 0,0,0, 1, (k == 0), 0),
           X((k <= 5), 0,0,0, 0,0,0, 0,0, (k <= 5)), $sformatf("mult%0d", k));

    // Reset asserted between edges during a div countdown with a live E tag.
    step(I(0,0,0,0,0,0, 1,7,2, 0,1,1), X(0, 0,0,0, 0,0,0, 0,0, 1), "rst_pre0");
    step(I(7,0,1,0,0,0, 0,0,0, 1,0,0), X(1, 1,7,2, 0,0,0, 0,0, 1), "rst_pre1");
    #1 reset = 1'b1;
    sb_q.push_back(X(0, 0,0,0, 0,0,0, 0,0, 0));
    #1;
    check("rst_async");
    #1 reset = 1'b0;
    step(I(0,0,0,0,0,0, 0,0,0, 1,0,0), X(0, 0,0,0, 0,0,0, 0,0, 0), "rst_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
